// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Branch resolution stage. Evaluates an RV32/RV64 conditional branch
//   (signed and unsigned compares), computes pc+imm, decides the resolved
//   direction, flags mispredictions and produces the redirect PC. Latency is
//   PIPE cycles (1 or 2) and throughput is one branch per cycle.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 kills every in-flight entry on the next edge
//   in_valid / in_ready   request handshake from execute
//   funct3, data1, data2  branch kind and rs1/rs2 values
//   pc, imm               branch PC and sign-extended offset
//   pred_taken/_target    front-end prediction
//   out_valid / out_ready result handshake to the consumer
//   cmp_result            one-hot signed compare {gt, lt, eq}
//   taken, target         resolved direction and pc+imm
//   redirect_pc           taken ? target : pc+4
//   mispredict, illegal   prediction wrong / funct3 is 010 or 011
//   branch_cnt            saturating count of delivered results
//   mispredict_cnt        saturating count of delivered mispredicts
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on internal state and out_ready, never on
// in_valid. While out_valid is high and out_ready is low every output holds.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int PIPE  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       cmp_result,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef struct packed {
        logic [2:0]      cmp;
        logic            taken;
        logic            illegal;
        logic            mispredict;
        logic [XLEN-1:0] redirect;
    } res_t;

    // Turns the raw compare flags into the architectural result.
    function automatic res_t resolve(
        input logic            eq,
        input logic            lt_s,
        input logic            lt_u,
        input logic [2:0]      f3,
        input logic [XLEN-1:0] tgt,
        input logic [XLEN-1:0] pc4,
        input logic            p_taken,
        input logic [XLEN-1:0] p_target
    );
        res_t r;
        r.cmp     = eq ? 3'b001 : (lt_s ? 3'b010 : 3'b100);
        r.taken   = 1'b0;
        r.illegal = 1'b0;
        case (f3)
            3'b000:  r.taken = eq;
            3'b001:  r.taken = !eq;
            3'b100:  r.taken = lt_s;
            3'b101:  r.taken = !lt_s;
            3'b110:  r.taken = lt_u;
            3'b111:  r.taken = !lt_u;
            default: r.illegal = 1'b1;
        endcase
        // An illegal branch resolves not-taken, so it mispredicts exactly
        // when the front end guessed taken.
        r.mispredict = (r.taken != p_taken) | (r.taken & p_taken & (tgt != p_target));
        r.redirect   = r.taken ? tgt : pc4;
        return r;
    endfunction

    // Front-end compare and address arithmetic (wraps modulo 2^XLEN).
    logic            eq_c;
    logic            lt_s_c;
    logic            lt_u_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc4_c;

    assign eq_c     = (data1 == data2);
    assign lt_s_c   = ($signed(data1) < $signed(data2));
    assign lt_u_c   = (data1 < data2);
    assign target_c = pc + imm;
    assign pc4_c    = pc + XLEN'(4);

    // Source feeding the output register: the inputs directly (PIPE=1) or
    // the stage-1 register (PIPE=2).
    logic            out_adv;
    logic            src_valid;
    res_t            src_res;
    logic [XLEN-1:0] src_target;

    // Output register can take a new entry when empty or being drained.
    assign out_adv = !out_valid | out_ready;

    generate
        if (PIPE == 1) begin : g_pipe1
            assign in_ready   = out_adv;
            assign src_valid  = in_valid;
            assign src_res    = resolve(eq_c, lt_s_c, lt_u_c, funct3, target_c, pc4_c,
                                        pred_taken, pred_target);
            assign src_target = target_c;
        end else begin : g_pipe2
            logic            s1_valid;
            logic            s1_eq;
            logic            s1_lt_s;
            logic            s1_lt_u;
            logic [2:0]      s1_funct3;
            logic [XLEN-1:0] s1_target;
            logic [XLEN-1:0] s1_pc4;
            logic            s1_pred_taken;
            logic [XLEN-1:0] s1_pred_target;

            assign in_ready = !s1_valid | out_adv;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid       <= 1'b0;
                    s1_eq          <= 1'b0;
                    s1_lt_s        <= 1'b0;
                    s1_lt_u        <= 1'b0;
                    s1_funct3      <= 3'b000;
                    s1_target      <= '0;
                    s1_pc4         <= '0;
                    s1_pred_taken  <= 1'b0;
                    s1_pred_target <= '0;
                end else begin
                    if (flush)
                        s1_valid <= 1'b0;
                    else if (in_ready)
                        s1_valid <= in_valid;
                    if (!flush && in_valid && in_ready) begin
                        s1_eq          <= eq_c;
                        s1_lt_s        <= lt_s_c;
                        s1_lt_u        <= lt_u_c;
                        s1_funct3      <= funct3;
                        s1_target      <= target_c;
                        s1_pc4         <= pc4_c;
                        s1_pred_taken  <= pred_taken;
                        s1_pred_target <= pred_target;
                    end
                end
            end

            assign src_valid  = s1_valid;
            assign src_res    = resolve(s1_eq, s1_lt_s, s1_lt_u, s1_funct3, s1_target,
                                        s1_pc4, s1_pred_taken, s1_pred_target);
            assign src_target = s1_target;
        end
    endgenerate

    // Payload only moves with a real entry, so outputs stay at their reset
    // value until the first result and never pick up dropped flush inputs.
    logic out_load;
    assign out_load = src_valid & out_adv & !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            cmp_result     <= 3'b000;
            taken          <= 1'b0;
            target         <= '0;
            redirect_pc    <= '0;
            mispredict     <= 1'b0;
            illegal        <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (out_adv)
                out_valid <= src_valid;
            if (out_load) begin
                cmp_result  <= src_res.cmp;
                taken       <= src_res.taken;
                target      <= src_target;
                redirect_pc <= src_res.redirect;
                mispredict  <= src_res.mispredict;
                illegal     <= src_res.illegal;
            end
            // A handshake in a flush cycle is still a delivered result.
            if (out_valid && out_ready) begin
                if (branch_cnt != '1)
                    branch_cnt <= branch_cnt + CNT_W'(1);
                if (mispredict && (mispredict_cnt != '1))
                    mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined branch resolution stage for the pipeline CPU. Accepts a conditional branch from execute (two operands, funct3, PC, immediate, front-end prediction), evaluates the RV32/RV64 branch condition with correct signed and unsigned semantics, computes the target, and flags mispredictions with a redirect PC. It has a valid/ready handshake on both sides, a configurable 1- or 2-stage latency, a synchronous flush, and saturating branch and mispredict counters for performance monitoring.

## Interface
- XLEN, 32, operand/PC width (32 or 64)
- PIPE, 1, pipeline depth in cycles (1 or 2)
- CNT_W, 16, width of each performance counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  synchronous; kills all in-flight entries
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept this cycle
- funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- data1, data2  input  XLEN  rs1 / rs2 values
- pc, imm  input  XLEN  branch PC; sign-extended offset
- pred_taken  input  1  front-end prediction
- pred_target  input  XLEN  predicted target
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- cmp_result  output  3  one-hot signed compare: 001 eq, 010 lt, 100 gt
- taken  output  1  resolved direction
- target  output  XLEN  pc + imm
- redirect_pc  output  XLEN  taken ? target : pc + 4
- mispredict  output  1  prediction wrong
- illegal  output  1  funct3 is 010 or 011
- branch_cnt, mispredict_cnt  output  CNT_W  saturating counters

## Operation
- Compare: eq = (data1 == data2); lt_s = true signed less-than (no overflow error, e.g. 0x7FFFFFFF vs 0x80000000 is gt); lt_u = unsigned less-than. cmp_result is always the signed one-hot view.
- taken: BEQ eq; BNE !eq; BLT lt_s; BGE !lt_s; BLTU lt_u; BGEU !lt_u; illegal funct3 → taken=0, illegal=1, mispredict=pred_taken.
- target and pc+4 wrap modulo 2^XLEN.
- mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
- PIPE=1: all of the above computed from inputs and registered into the single output stage.
- PIPE=2: stage 1 registers eq/lt_s/lt_u, funct3, target, pc+4, prediction; stage 2 derives taken/mispredict/redirect_pc and registers outputs.
- Each stage holds a valid bit. A stage loads when it is empty or its successor takes its contents in the same cycle. in_ready = !first_stage_valid | first_stage_advances (combinational from out_ready; no path from in_valid).
- Counters: on each output handshake (out_valid & out_ready) branch_cnt += 1; mispredict_cnt += 1 if mispredict. Both saturate at all-ones, never wrap.
- flush: clears all valid bits next edge; an input presented in the flush cycle is dropped; an output handshake in the flush cycle still counts. Counters are not cleared by flush.
- rst_n low: all valid bits 0, counters 0, all payload outputs 0. Reset overrides flush and any handshake.

## Timing
- Latency: accept at edge N → out_valid at edge N+PIPE.
- Throughput: one branch per cycle while out_ready stays high.
- Back-pressure: while out_valid & !out_ready, all outputs hold stable; with PIPE=2 stage 1 may still fill once, then in_ready drops.
- Outputs after reset, before any accept: out_valid=0, in_ready=1, cmp_result=000, taken=0, target=0, redirect_pc=0, mispredict=0, illegal=0, counters 0.
- Reset mid-operation: in-flight entries lost, no counter update on that edge.

## Test plan
- PIPE=1, out_ready=1, BLT data1=0x7FFFFFFF data2=0x80000000 pred_taken=1 → 1 cycle later taken=0, cmp_result=100, mispredict=1, redirect_pc=pc+4, mispredict_cnt=1.
- BLTU same operands, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → taken=1, target=0x120, mispredict=0; with pred_target=0x124 → mispredict=1.
- PIPE=2, 8 back-to-back BEQ with out_ready=1 → 8 results in consecutive cycles starting 2 cycles after first accept, branch_cnt=8; then out_ready=0 for 3 cycles → outputs stable, in_ready falls after stage 1 fills.
- flush asserted with two entries in flight and in_valid=1 → next cycle out_valid=0, no stale output ever appears, counters unchanged.
- funct3=010 pred_taken=0 → illegal=1, taken=0, mispredict=0; CNT_W=2 with 5 mispredicts → mispredict_cnt holds at 3.
- pc=0xFFFFFFFC, imm=8, XLEN=32 → target=0x4; not taken → redirect_pc=0x0.
